// File: rtl/mac_chk_pkg.sv
// Shared types, constants and helpers for the MAC frame checker.
// PRBS8 helpers model the x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
package mac_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_FCS,
        ST_DATA,
        ST_DROP
    } state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned PRE_LEN       = 7;
    localparam int unsigned HDR_LEN       = 14;
    localparam int unsigned FCS_LEN       = 4;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [7:0]  MODE_NONE     = 8'd0;
    localparam logic [7:0]  MODE_FIXED    = 8'd1;
    localparam logic [7:0]  MODE_PRBS8    = 8'd3;

    localparam int unsigned ERR_PRE       = 0;
    localparam int unsigned ERR_LEN       = 1;
    localparam int unsigned ERR_PAY       = 2;
    localparam int unsigned ERR_FCS       = 3;
    localparam int unsigned ERR_TRUNC     = 4;
    localparam int unsigned ERR_W         = 5;

    function automatic logic [7:0] prbs8_seed(input logic [7:0] seed);
        return (seed == 8'h00) ? 8'hFF : seed;
    endfunction

    // Output bit is s[7] shifted out MSB first, so a whole expected byte equals
    // the current state; the state then moves on by eight shifts.
    function automatic logic [7:0] prbs8_advance(input logic [7:0] s);
        logic [7:0] r;
        r = s;
        for (int unsigned i = 0; i < 8; i++) begin
            r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_crc32_byte.sv
// Combinational CRC32 (reflected 0xEDB88320) update by one byte, LSB first.
module mac_crc32_byte (
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h00_0000, data};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/mac_frame_checker.sv
// Receive-side MAC frame checker: header capture, payload/length/FCS checks, per-frame verdict.
// Define MAC_CHK_STATS_EN to add wrapping good/bad frame counters.
module mac_frame_checker
    import mac_chk_pkg::*;
#(
    parameter int unsigned PAYLOAD_MAX_SIZE     = 1500,
    parameter logic [7:0]  PAYLOAD_CHAR_PATTERN = 8'h55
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    input  logic        i_last,
    input  logic [7:0]  i_mode,
    input  logic [7:0]  i_prbs_seed,
    input  logic        i_prbs_load,
    output logic        o_done,
    output logic        o_frame_ok,
    output logic [4:0]  o_err,
    output logic [47:0] o_dest_address,
    output logic [47:0] o_src_address,
    output logic [15:0] o_length,
    output logic [15:0] o_payload_err_cnt
`ifdef MAC_CHK_STATS_EN
    ,
    output logic [31:0] o_frames_ok,
    output logic [31:0] o_frames_bad
`endif
);

    state_t             state, state_nxt;
    logic [2:0]         pre_cnt;
    logic [15:0]        byte_cnt;
    logic [31:0]        crc, crc_nxt;
    logic [7:0]         prbs;
    logic [7:0]         mode;
    logic [ERR_W-1:0]   err_acc, err_set, err_fin;
    logic [15:0]        len_nxt;
    logic               pay_mismatch;
    logic               verdict, pre_start, pre_inc, sfd_hit, hdr_byte, pay_byte;
    logic               crc_en, cnt_inc, cnt_clr;

    mac_crc32_byte u_crc (
        .crc      (crc),
        .data     (i_data),
        .crc_next (crc_nxt)
    );

    assign len_nxt = {o_length[7:0], i_data};

    always_comb begin
        pay_mismatch = 1'b0;
        case (mode)
            MODE_FIXED: pay_mismatch = (i_data != PAYLOAD_CHAR_PATTERN);
            MODE_PRBS8: pay_mismatch = (i_data != prbs);
            default:    pay_mismatch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = '0;
        verdict   = 1'b0;
        pre_start = 1'b0;
        pre_inc   = 1'b0;
        sfd_hit   = 1'b0;
        hdr_byte  = 1'b0;
        pay_byte  = 1'b0;
        crc_en    = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        if (i_valid) begin
            case (state)
                ST_IDLE: begin
                    if (i_data == PREAMBLE_BYTE) begin
                        pre_start = 1'b1;
                        state_nxt = ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (i_data == PREAMBLE_BYTE) begin
                        pre_inc = 1'b1;
                    end else if (i_data == SFD_BYTE && pre_cnt >= 3'(PRE_LEN)) begin
                        sfd_hit   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = ST_HDR;
                    end else begin
                        err_set[ERR_PRE] = 1'b1;
                        state_nxt        = ST_DROP;
                    end
                    if (i_last) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        verdict            = 1'b1;
                    end
                end
                ST_HDR: begin
                    hdr_byte = 1'b1;
                    crc_en   = 1'b1;
                    cnt_inc  = 1'b1;
                    if (byte_cnt == 16'(HDR_LEN - 1)) begin
                        cnt_clr = 1'b1;
                        if (len_nxt == '0) begin
                            state_nxt = ST_FCS;
                        end else if ({16'd0, len_nxt} <= PAYLOAD_MAX_SIZE) begin
                            state_nxt = ST_PAY;
                        end else begin
                            state_nxt = ST_DATA;
                        end
                    end
                    if (i_last) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        verdict            = 1'b1;
                    end
                end
                ST_PAY: begin
                    pay_byte = 1'b1;
                    crc_en   = 1'b1;
                    cnt_inc  = 1'b1;
                    if (pay_mismatch) begin
                        err_set[ERR_PAY] = 1'b1;
                    end
                    if (byte_cnt == o_length - 16'd1) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_FCS;
                    end
                    if (i_last) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        err_set[ERR_LEN]   = 1'b1;
                        verdict            = 1'b1;
                    end
                end
                ST_FCS: begin
                    crc_en  = 1'b1;
                    cnt_inc = 1'b1;
                    if (byte_cnt == 16'(FCS_LEN - 1)) begin
                        if (i_last) begin
                            verdict = 1'b1;
                        end else begin
                            err_set[ERR_LEN] = 1'b1;
                            cnt_clr          = 1'b1;
                            state_nxt        = ST_DROP;
                        end
                    end else if (i_last) begin
                        err_set[ERR_TRUNC] = 1'b1;
                        err_set[ERR_LEN]   = 1'b1;
                        verdict            = 1'b1;
                    end
                end
                ST_DATA: begin
                    crc_en  = 1'b1;
                    cnt_inc = 1'b1;
                    if (i_last) begin
                        verdict = 1'b1;
                        if (byte_cnt < 16'(FCS_LEN - 1)) begin
                            err_set[ERR_TRUNC] = 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    crc_en = 1'b1;
                    if (i_last) begin
                        verdict = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (verdict) begin
            state_nxt = ST_IDLE;
            cnt_clr   = 1'b1;
        end
    end

    // CRC residue is only meaningful when the frame was framed and complete.
    always_comb begin
        err_fin = err_acc | err_set;
        if (!err_fin[ERR_PRE] && !err_fin[ERR_TRUNC] && crc_nxt != CRC_RESIDUE) begin
            err_fin[ERR_FCS] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pre_cnt           <= '0;
            byte_cnt          <= '0;
            crc               <= CRC_INIT;
            prbs              <= prbs8_seed(i_prbs_seed);
            mode              <= MODE_NONE;
            err_acc           <= '0;
            o_done            <= 1'b0;
            o_frame_ok        <= 1'b0;
            o_err             <= '0;
            o_dest_address    <= '0;
            o_src_address     <= '0;
            o_length          <= '0;
            o_payload_err_cnt <= '0;
        end else begin
            if (pre_start) begin
                pre_cnt <= 3'd1;
            end else if (pre_inc && pre_cnt < 3'(PRE_LEN)) begin
                pre_cnt <= pre_cnt + 3'd1;
            end

            if (cnt_clr) begin
                byte_cnt <= '0;
            end else if (cnt_inc && byte_cnt != '1) begin
                byte_cnt <= byte_cnt + 16'd1;
            end

            if (verdict || pre_start) begin
                err_acc <= '0;
            end else begin
                err_acc <= err_acc | err_set;
            end

            if (sfd_hit) begin
                crc <= CRC_INIT;
            end else if (crc_en) begin
                crc <= crc_nxt;
            end

            if (sfd_hit) begin
                mode <= i_mode;
            end

            // A load on the same cycle as a PAY byte wins; that byte was already
            // compared against the old state through pay_mismatch.
            if (i_prbs_load) begin
                prbs <= prbs8_seed(i_prbs_seed);
            end else if (pay_byte && mode == MODE_PRBS8) begin
                prbs <= prbs8_advance(prbs);
            end

            if (sfd_hit) begin
                o_payload_err_cnt <= '0;
            end else if (pay_byte && pay_mismatch && o_payload_err_cnt != '1) begin
                o_payload_err_cnt <= o_payload_err_cnt + 16'd1;
            end

            if (sfd_hit) begin
                o_dest_address <= '0;
                o_src_address  <= '0;
                o_length       <= '0;
            end else if (hdr_byte) begin
                if (byte_cnt < 16'd6) begin
                    o_dest_address <= {o_dest_address[39:0], i_data};
                end else if (byte_cnt < 16'd12) begin
                    o_src_address <= {o_src_address[39:0], i_data};
                end else begin
                    o_length <= {o_length[7:0], i_data};
                end
            end

            o_done <= verdict;
            if (verdict) begin
                o_err      <= err_fin;
                o_frame_ok <= (err_fin == '0);
            end
        end
    end

`ifdef MAC_CHK_STATS_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_frames_ok  <= '0;
            o_frames_bad <= '0;
        end else if (verdict) begin
            if (err_fin == '0) begin
                o_frames_ok <= o_frames_ok + 32'd1;
            end else begin
                o_frames_bad <= o_frames_bad + 32'd1;
            end
        end
    end
`endif

endmodule
